// File: rtl/foc_pkg.sv
// Types shared across the FOC sensor front-end blocks.
package foc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } period_state_t;

endpackage

// File: rtl/period_meter_if.sv
// Pulse input, enable and measurement results of period_meter.
interface period_meter_if #(
  parameter int W = 24
);

  logic         en;
  logic         pulse_in;
  logic [W-1:0] period;
  logic         period_valid;
  logic         stalled;
  logic         glitch;

  modport master (
    output en, pulse_in,
    input  period, period_valid, stalled, glitch
  );

  modport slave (
    input  en, pulse_in,
    output period, period_valid, stalled, glitch
  );

endinterface

// File: rtl/pulse_sync.sv
// Synchronizer for an asynchronous pulse plus registered rising-edge detect.
module pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~dly_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/period_meter.sv
// Measures the clk-cycle interval between rising edges of an async pulse train,
// with glitch rejection and stall timeout.
module period_meter
  import foc_pkg::*;
#(
  parameter int W           = 24,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 100,
  parameter int MAX_PERIOD  = 1_000_000
) (
  input logic           clk,
  input logic           nrst,
  period_meter_if.slave bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("period_meter: SYNC_STAGES must be >= 2");
  end
  if (MIN_PERIOD < 2) begin : g_bad_min
    $error("period_meter: MIN_PERIOD must be >= 2");
  end
  if (MIN_PERIOD >= MAX_PERIOD) begin : g_bad_order
    $error("period_meter: MIN_PERIOD must be < MAX_PERIOD");
  end
  if (64'(MAX_PERIOD) >= (64'd1 << W)) begin : g_bad_max
    $error("period_meter: MAX_PERIOD must fit in W bits");
  end

  localparam logic [W-1:0] MIN_P = W'(MIN_PERIOD);
  localparam logic [W-1:0] MAX_P = W'(MAX_PERIOD);
  localparam logic [W-1:0] ONE   = W'(1);

  logic rise;

  pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .din  (bus.pulse_in),
    .rise (rise)
  );

  period_state_t state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  period_q, period_d;
  logic          valid_q, valid_d;
  logic          stalled_q, stalled_d;
  logic          glitch_q, glitch_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;
    glitch_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise && bus.en) begin
          state_d = MEASURE;
          cnt_d   = ONE;
        end
      end
      MEASURE: begin
        // An edge landing on cnt == MAX_P is a valid measurement, so it is tested before the timeout.
        if (!bus.en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rise && (cnt_q >= MIN_P)) begin
          period_d  = cnt_q;
          valid_d   = 1'b1;
          stalled_d = 1'b0;
          cnt_d     = ONE;
        end else if (rise) begin
          glitch_d = 1'b1;
          cnt_d    = cnt_q + ONE;
        end else if (cnt_q == MAX_P) begin
          period_d  = '0;
          valid_d   = 1'b1;
          stalled_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b1;
      glitch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
      glitch_q  <= glitch_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.stalled      = stalled_q;
  assign bus.glitch       = glitch_q;

endmodule

// File: doc/period_meter.md
# period_meter

Measures the interval, in `clk` cycles, between rising edges of an asynchronous pulse train, such as a Hall sensor or an encoder index. It is the receive-side counterpart of the control-tick divider: the divider turns a cycle count into a periodic strobe, and this block turns a periodic strobe back into a cycle count. It sits between the sensor input pins and the speed-estimation logic of the FOC loop. Each accepted edge produces a one-cycle `period_valid` strobe with the measured period.

## Interface

Parameters:
- `W`, 24: width of the period counter and the `period` output.
- `SYNC_STAGES`, 2: flip-flop stages in the input synchronizer; must be ≥ 2.
- `MIN_PERIOD`, 100: shortest accepted period in cycles; shorter edges are rejected as glitches; must be ≥ 2.
- `MAX_PERIOD`, 1_000_000: stall timeout in cycles (10 ms at 100 MHz); requires `MIN_PERIOD < MAX_PERIOD < 2**W`.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `nrst` in 1: reset, asynchronous, active-low.
- `en` in 1: measurement enable.
- `pulse_in` in 1: asynchronous sensor pulse; only rising edges are used.
- `period` out W: last measured period in cycles; 0 means stalled.
- `period_valid` out 1: one-cycle strobe; `period` was updated this cycle.
- `stalled` out 1: level; no accepted edge within `MAX_PERIOD` cycles.
- `glitch` out 1: one-cycle strobe; an edge was rejected as too short.

## Operation

- **Input path:** `pulse_in` → `SYNC_STAGES` synchronizer → one delay register. `edge` = synchronized value high and delayed value low.
- **Reset values:** `period`=0, `period_valid`=0, `glitch`=0, `stalled`=1, counter `cnt`=0, state IDLE, all synchronizer flops 0.
- **States:** IDLE (waiting for a reference edge) and MEASURE.
- **IDLE:**
  - `cnt` is held at 0.
  - On `edge` with `en`=1: go to MEASURE, `cnt`←1, no strobe.
- **MEASURE, each cycle, in priority order:**
  1. `en`=0: go to IDLE, `cnt`←0; `period` and `stalled` hold.
  2. `edge` and `cnt` ≥ `MIN_PERIOD`: `period`←`cnt`, `period_valid`=1, `stalled`←0, `cnt`←1.
  3. `edge` and `cnt` < `MIN_PERIOD`: `glitch`=1, `cnt`←`cnt`+1; the reference edge is unchanged.
  4. `cnt` = `MAX_PERIOD`: `period`←0, `period_valid`=1, `stalled`←1, go to IDLE, `cnt`←0.
  5. Otherwise: `cnt`←`cnt`+1.
- **Simultaneous edge and `cnt`=`MAX_PERIOD`:** the edge wins. `period`=`MAX_PERIOD`, valid strobe, and the block stays in MEASURE.
- **`en`=0 in IDLE:** no state change. Edges are ignored, but the synchronizer keeps running so no false edge appears on re-enable.
- **Re-enable:** an edge in the same cycle that `en` rises is taken as the IDLE reference edge.
- **Counter range:** `cnt` never exceeds `MAX_PERIOD`, so it never wraps.
- **Strobe exclusivity:** `period_valid` and `glitch` are never high in the same cycle.
- **Register timing:** `period` changes only in cycles where `period_valid` is high. All outputs are registered.

## Timing

- **Measured value:** rising edges on `pulse_in` exactly P cycles apart, with P in [`MIN_PERIOD`, `MAX_PERIOD`], give `period`=P.
- **Latency:** `period_valid` rises `SYNC_STAGES`+2 cycles after the first `clk` edge that samples `pulse_in` high. That is `SYNC_STAGES` synchronizer cycles, 1 cycle to form `edge`, and 1 cycle of output register.
- **Stall detection:** the timeout strobe comes `MAX_PERIOD` cycles after the last accepted reference edge (+1 output-register cycle).
- **Startup:** after reset or stall, the first edge only arms the block. The first measurement comes at the second edge.
- **Reset mid-measurement:** all state returns to reset values immediately and asynchronously. Deassertion is synchronized externally; the block needs no extra handling.

## Structure

- Shared `foc_pkg`: `period_state_t` enum {IDLE, MEASURE}.
- Sub-module `pulse_sync` (synchronizer plus edge detect, parameter `SYNC_STAGES`). It is reused for Hall and encoder inputs.
- `period_meter` holds the FSM, counter and output registers. It checks its parameter constraints with elaboration-time assertions.

## Test plan

Bench parameters: `W`=8, `SYNC_STAGES`=2, `MIN_PERIOD`=4, `MAX_PERIOD`=50, `en`=1.

- **Steady train:** edges every 20 cycles → first edge gives no strobe; each later edge gives `period_valid` with `period`=20 and `stalled`=0; strobe arrives 4 cycles after `pulse_in` is sampled high.
- **Glitch:** edges at t=0, 2, 20 → `glitch` pulses once (edge at 2); `period`=20 at the edge at 20; no `period_valid` for the glitch.
- **Stall:** one edge, then none → after 50 cycles `period_valid` with `period`=0 and `stalled`=1; the next edge only arms; the edge after it measures and clears `stalled`.
- **Boundary:** edges exactly 50 apart → `period`=50 and no stall; edges exactly 4 apart → `period`=4; edges 3 apart → `glitch`.
- **Enable:** drop `en` mid-period → no strobes, `period` held; raise `en`, edges 10 apart → first edge arms, second gives `period`=10.
- **Async reset:** assert `nrst` mid-count, off a `clk` edge → all outputs are immediately at reset values (`stalled`=1), with no strobe after release.
